// File: rtl/hwpe_stream_tcdm_store_lane.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_tcdm_store_lane
// Description : Turns one 32-bit HWPE-Stream lane into TCDM write requests.
//               It has a strided address generator, a beat counter and its own
//               job state. done_o pulses once after the programmed number of
//               words has been written.
//               Optional macro HWPE_STREAM_TCDM_STORE_LANE_SKIP_EMPTY_STRB_EN:
//               when it is defined, beats with an all-zero strobe are consumed
//               without a TCDM request.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_stream_tcdm_store_lane #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [CNT_WIDTH-1:0]  nb_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  // push_i lane stream (sink)
  input  logic [31:0]           push_data_i,
  input  logic [3:0]            push_strb_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  // tcdm master port
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [3:0]            tcdm_be_o,
  output logic [31:0]           tcdm_data_o,
  input  logic [31:0]           tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  nb_q, nb_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fire;

  // This is a store-only lane, so the read response channel is not used.
  logic unused_rsp;
  assign unused_rsp = ^{tcdm_r_data_i, tcdm_r_valid_i};

  // The data path passes straight through with no buffering, so beat order is preserved.
  assign tcdm_add_o  = addr_q;
  assign tcdm_wen_o  = 1'b0;
  assign tcdm_be_o   = push_strb_i;
  assign tcdm_data_o = push_data_i;

  // State register and job parameters. clear_i has the same effect as reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      nb_q     <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      nb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      nb_q     <= nb_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic, handshake outputs and address/count advance.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    nb_d         = nb_q;
    cnt_d        = cnt_q;
    busy_o       = (state_q != IDLE);
    done_o       = 1'b0;
    tcdm_req_o   = 1'b0;
    push_ready_o = 1'b0;
    fire         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          stride_d = stride_i;
          nb_d     = nb_words_i;
          cnt_d    = '0;
          state_d  = (nb_words_i != '0) ? RUN : DONE;
        end
      end

      RUN: begin
`ifdef HWPE_STREAM_TCDM_STORE_LANE_SKIP_EMPTY_STRB_EN
        if (push_strb_i == 4'b0000) begin
          // An empty beat is consumed locally but still occupies its address slot.
          push_ready_o = 1'b1;
          fire         = push_valid_i;
        end else begin
          tcdm_req_o   = push_valid_i;
          push_ready_o = tcdm_gnt_i;
          fire         = push_valid_i & tcdm_gnt_i;
        end
`else
        tcdm_req_o   = push_valid_i;
        push_ready_o = tcdm_gnt_i;
        fire         = push_valid_i & tcdm_gnt_i;
`endif
        if (fire) begin
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q + CNT_WIDTH'(1);
          // nb_q is nonzero in RUN, so nb_q-1 does not underflow and cnt_q never wraps.
          if (cnt_q == nb_q - CNT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/hwpe_stream_tcdm_store_lane.md
Name: hwpe_stream_tcdm_store_lane

Overview:
Downstream consumer of one 32-bit lane produced by the stream splitter. It turns that HWPE-Stream into a sequence of TCDM write requests, one word per beat, with its own strided address generator. It also owns the job state, counts beats and pulses done after the programmed number of words. One instance sits per split lane, between the splitter output and a TCDM master port of the HWPE.

Parameters:
- ADDR_WIDTH, 32, width of TCDM address, base and stride.
- CNT_WIDTH, 16, width of word counter and nb_words_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear; same effect as reset.
- start_i  in  1  job start pulse; honoured only in IDLE.
- base_addr_i  in  ADDR_WIDTH  byte address of first word; sampled on start.
- stride_i  in  ADDR_WIDTH  byte increment per word, two's complement; sampled on start.
- nb_words_i  in  CNT_WIDTH  words in job; sampled on start.
- busy_o  out  1  high while state is not IDLE.
- done_o  out  1  one-cycle pulse at job end.
- push_i  sink  hwpe_stream_intf_stream, DATA_WIDTH=32  lane stream (data, strb, valid, ready).
- tcdm  master  hwpe_stream_intf_tcdm  req, gnt, add, wen, be, data; r_data and r_valid are ignored.

Behaviour:
- Reset/clear: state=IDLE, addr_q=0, cnt_q=0, nb_q=0, stride_q=0. busy_o=0, done_o=0, tcdm.req=0, push_i.ready=0.
- States:
  - IDLE.
  - IDLE -> RUN: on start_i when nb_words_i!=0. Latch addr_q=base_addr_i, stride_q=stride_i, nb_q=nb_words_i, cnt_q=0.
  - IDLE -> DONE: on start_i when nb_words_i==0. No TCDM traffic.
  - RUN -> DONE: on the fire where cnt_q==nb_q-1.
  - DONE -> IDLE: unconditionally after one cycle. done_o=1 only in DONE.
- start_i outside IDLE is ignored. The latched parameters do not change mid-job.
- In RUN:
  - tcdm.req = push_i.valid.
  - tcdm.add = addr_q.
  - tcdm.wen = 0 (write).
  - tcdm.be = push_i.strb.
  - tcdm.data = push_i.data.
  - push_i.ready = tcdm.gnt.
  - fire = push_i.valid & tcdm.gnt.
  - On fire: addr_q += stride_q, modulo 2^ADDR_WIDTH (wrap, no saturation); cnt_q += 1.
- Outside RUN: tcdm.req=0 and push_i.ready=0. Upstream beats stall and are never dropped.
- Latency:
  - First request is combinational on the first cycle of RUN, one cycle after start.
  - Throughput is one word per cycle when gnt is held high.
  - done_o rises the cycle after the last fire.
- Handshake rules:
  - req is never asserted without valid.
  - Once valid is high, upstream holds data/strb until ready; req therefore stays stable until gnt.
  - gnt without req has no effect.
- Boundaries:
  - nb_words_i=2^CNT_WIDTH-1 completes without counter overflow.
  - Negative stride decrements the address.
  - Simultaneous clear_i and start_i: clear wins, state=IDLE.
  - Reset or clear mid-job aborts immediately. No done pulse; pending beats stay upstream.
- Because the splitter broadcasts valid and ANDs readies, lanes stall together. This block adds no buffering, so data ordering is preserved.

Optional Feature:
Macro HWPE_STREAM_TCDM_STORE_LANE_SKIP_EMPTY_STRB_EN.
- Defined: in RUN, a beat with push_i.strb==4'b0000 is not sent to TCDM.
  - tcdm.req=0, push_i.ready=1 for that beat.
  - It counts as a fire: address and count still advance.
  - Nonzero-strb beats behave as normal.
- Undefined: every beat issues a request with be=strb, including be=0.

Test Plan:
- Basic job: base=0x1000, stride=4, nb=4, gnt=1, words A0..A3 valid back-to-back -> add 0x1000,0x1004,0x1008,0x100C; one beat per cycle; done_o pulses exactly once, one cycle after the 4th fire; busy_o=0 after.
- Grant stalls: base=0x2000, stride=8, nb=3, gnt low 2 cycles per word -> req, add and data held stable while gnt=0; push_i.ready tracks gnt; addresses 0x2000,0x2008,0x2010.
- Negative stride and wrap: base=0x4, stride=0xFFFFFFFC, nb=3 -> add 0x4,0x0,0xFFFFFFFC.
- Zero-length and ignored start: nb=0 -> done_o pulses one cycle after start with no req. A start asserted during RUN of an nb=5 job -> job still completes 5 words with the original base.
- Abort: clear_i asserted after 2 of 6 words -> next cycle busy_o=0, no done pulse, push_i.ready=0. A new start with base=0x100 restarts at 0x100.
- Optional feature: strb pattern F,0,3,0 with base=0, stride=4 -> defined: requests only at 0x0 (be=F) and 0x8 (be=3), done after 4 beats. Undefined: 4 requests including be=0.
